pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control unit for the 16-bit ASIP core: drives the load enables and flush (bubble) controls of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipe registers and the PC. It resolves three hazard classes in fixed priority:
- memory-stage wait (freeze);
- taken jump resolved in EXE (redirect + two-cycle front-end flush);
- load-use dependency (one-cycle bubble).

It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

## Interface
Parameters:
- REG_W, 4, register-index width
- MEM_TIMEOUT, 15, max consecutive frozen cycles waiting on mem_ready (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  REG_W  source register indices of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- exe_rd  in  REG_W  destination index of instruction in EXE
- exe_rd_mem_en  in  1  EXE instruction is a load
- exe_wb_en  in  1  EXE instruction writes back
- exe_jump_taken  in  1  jump in EXE resolved taken this cycle
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC load enable
- ifid_en, idexe_en, exemem_en, memwb_en  out  1  pipe-register load enables
- ifid_flush, idexe_flush  out  1  load a bubble (all-zero) into IF/ID, ID/EXE
- state  out  2  current FSM state (debug)
- stall_cycles  out  16  count of cycles with pc_en=0, saturating at 0xFFFF
- mem_timeout  out  1  sticky: a MEM_WAIT was force-released

## Operation
FSM states: RUN=0, MEM_WAIT=1, FLUSH=2. Outputs are combinational from state and current inputs. Registered: state, wait_cnt ($clog2(MEM_TIMEOUT+1) bits), stall_cycles, mem_timeout.
- load_use = exe_rd_mem_en & exe_wb_en & ((id_uses_rs1 & id_rs1==exe_rd) | (id_uses_rs2 & id_rs2==exe_rd)).
- Default (no hazard): all enables 1, all flushes 0.

RUN, evaluated in priority order:
1. mem_req & !mem_ready: all enables 0, flushes 0; wait_cnt←1; next MEM_WAIT.
2. exe_jump_taken: all enables 1, ifid_flush=1, idexe_flush=1; next FLUSH.
3. load_use: pc_en=0, ifid_en=0, idexe_en=1 with idexe_flush=1, exemem_en=1, memwb_en=1; stay RUN.
4. Otherwise: default; stay RUN.
- mem_req & mem_ready in the same cycle → no stall.

MEM_WAIT:
- mem_ready=1: default outputs (release); next RUN.
- Else if wait_cnt==MEM_TIMEOUT: default outputs (forced release); mem_timeout←1; next RUN.
- Else: all enables 0; wait_cnt←wait_cnt+1.
- exe_jump_taken and load_use are ignored here. They are re-evaluated in RUN because EXE is frozen.

FLUSH:
- Default outputs except ifid_flush=1. This kills the fetch issued before the redirect under synchronous instruction memory. Next RUN.
- mem_req & !mem_ready in FLUSH: freeze as in RUN rule 1 (ifid_flush=0) and go to MEM_WAIT. The pending IF/ID kill is dropped; the fetch unit must hold the redirected PC.

Other rules:
- stall_cycles increments on every non-reset cycle with pc_en=0 and saturates at 0xFFFF.
- mem_timeout is cleared only by rst.

## Timing
- Reset: state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0. While rst=1, all enables and flushes are driven 0. In the first cycle after reset with idle inputs, all enables are 1.
- rst mid-MEM_WAIT or mid-FLUSH: the next cycle is RUN with counters cleared and no residual flush.
- Load-use costs exactly 1 bubble. A taken jump costs 2 bubbles (2 cycles with ifid_flush). Memory wait of N cycles costs N frozen cycles, max MEM_TIMEOUT.
- The hazard decision is visible in the same cycle as its inputs. Pipe registers act on it at the next posedge.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum ctrl_state_t {RUN, MEM_WAIT, FLUSH};
  - struct pipe_ctrl_t bundling pc_en, the four enables and the two flushes;
  - constant CTRL_DEFAULT, all enables 1 and flushes 0.
- Sub-module load_use_detect is purely combinational: it implements the load_use equation above and is parameterised by REG_W.

## Test plan
- Idle after reset: any non-hazard inputs → all enables 1, flushes 0, stall_cycles stays 0.
- Load-use: exe_rd=3, exe_rd_mem_en=1, exe_wb_en=1, id_rs2=3, id_uses_rs2=1 → one cycle with pc_en=0, ifid_en=0, idexe_flush=1; stall_cycles=1. Same case with id_uses_rs2=0 → no stall.
- Jump: exe_jump_taken=1 → cycle 0 ifid_flush=idexe_flush=1, cycle 1 ifid_flush=1 only (state=2), cycle 2 default.
- Mem wait: mem_req=1, mem_ready low for 3 cycles, then high → exactly 3 frozen cycles, release on the mem_ready cycle, mem_timeout=0.
- Timeout: MEM_TIMEOUT=15, mem_ready stuck 0 → 15 frozen cycles, release on the 16th, mem_timeout=1 on the next cycle and held until rst.
- Priority and reset: mem stall plus jump plus load_use in the same RUN cycle → freeze only, and the jump is honoured after release. Asserting rst during MEM_WAIT → next cycle is RUN, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the bundled
// pipe-register control word.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idexe_en;
    logic exemem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idexe_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_DEFAULT = '{
    pc_en: 1'b1, ifid_en: 1'b1, idexe_en: 1'b1, exemem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b0, idexe_flush: 1'b0
  };

  localparam pipe_ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load sitting in EXE.
module load_use_detect #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             exe_rd_mem_en,
  input  logic             exe_wb_en,
  output logic             load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_uses_rs1 && (id_rs1 == exe_rd);
  assign w_rs2_hit = id_uses_rs2 && (id_rs2 == exe_rd);
  assign load_use  = exe_rd_mem_en && exe_wb_en && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: memory freeze, taken-jump flush and load-use bubble in fixed
// priority, plus a saturating stall counter and a sticky memory-timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             exe_rd_mem_en,
  input  logic             exe_wb_en,
  input  logic             exe_jump_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idexe_en,
  output logic             exemem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idexe_flush,
  output logic [1:0]       state,
  output logic [15:0]      stall_cycles,
  output logic             mem_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t r_state;
  ctrl_state_t w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_next_wait_cnt;
  logic [15:0] r_stall_cycles;
  logic r_mem_timeout;
  logic w_set_timeout;
  logic w_load_use;
  logic w_mem_stall;
  pipe_ctrl_t w_ctrl;
  pipe_ctrl_t w_out;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .exe_rd        (exe_rd),
    .exe_rd_mem_en (exe_rd_mem_en),
    .exe_wb_en     (exe_wb_en),
    .load_use      (w_load_use)
  );

  assign w_mem_stall = mem_req && !mem_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_ctrl          = CTRL_DEFAULT;
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_set_timeout   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_ctrl          = CTRL_FREEZE;
          w_next_wait_cnt = CNT_W'(1);
          w_next_state    = MEM_WAIT;
        end else if (exe_jump_taken) begin
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idexe_flush = 1'b1;
          w_next_state       = FLUSH;
        end else if (w_load_use) begin
          w_ctrl.pc_en       = 1'b0;
          w_ctrl.ifid_en     = 1'b0;
          w_ctrl.idexe_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_next_state = RUN;
        end else if (r_wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          w_set_timeout = 1'b1;
          w_next_state  = RUN;
        end else begin
          w_ctrl          = CTRL_FREEZE;
          w_next_wait_cnt = r_wait_cnt + CNT_W'(1);
        end
      end
      FLUSH: begin
        // A freeze here drops the pending IF/ID kill; fetch holds the redirected PC.
        if (w_mem_stall) begin
          w_ctrl          = CTRL_FREEZE;
          w_next_wait_cnt = CNT_W'(1);
          w_next_state    = MEM_WAIT;
        end else begin
          w_ctrl.ifid_flush = 1'b1;
          w_next_state      = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_mem_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if (!w_ctrl.pc_en && r_stall_cycles != 16'hFFFF)
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_set_timeout)
        r_mem_timeout <= 1'b1;
    end
  end

  assign w_out = rst ? CTRL_FREEZE : w_ctrl;

  assign pc_en        = w_out.pc_en;
  assign ifid_en      = w_out.ifid_en;
  assign idexe_en     = w_out.idexe_en;
  assign exemem_en    = w_out.exemem_en;
  assign memwb_en     = w_out.memwb_en;
  assign ifid_flush   = w_out.ifid_flush;
  assign idexe_flush  = w_out.idexe_flush;
  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;
  assign mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control words are queued as each
// vector is driven and popped when the outputs are sampled mid-cycle.
module tb_pipe_hazard_ctrl;

  // {pc_en, ifid_en, idexe_en, exemem_en, memwb_en, ifid_flush, idexe_flush}
  localparam logic [6:0] C_DEF = 7'b1111100;
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_LU  = 7'b0011101;
  localparam logic [6:0] C_JMP = 7'b1111111;
  localparam logic [6:0] C_FL  = 7'b1111110;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_FL  = 2'd2;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs1, id_rs2, exe_rd;
  logic        id_uses_rs1, id_uses_rs2, exe_rd_mem_en, exe_wb_en;
  logic        exe_jump_taken, mem_req, mem_ready;
  logic        pc_en, ifid_en, idexe_en, exemem_en, memwb_en, ifid_flush, idexe_flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .exe_rd(exe_rd), .exe_rd_mem_en(exe_rd_mem_en), .exe_wb_en(exe_wb_en),
    .exe_jump_taken(exe_jump_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idexe_en(idexe_en), .exemem_en(exemem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idexe_flush(idexe_flush),
    .state(state), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  // Called just after a negedge with inputs already set; ends on the next negedge.
  task automatic step(input logic [6:0] ec, input logic [1:0] es,
                      input logic [15:0] esc, input logic et);
    exp_t e;
    exp_q.push_back('{ctrl: ec, st: es, sc: esc, to: et});
    #2;
    e = exp_q.pop_front();
    check("ctrl", 16'({pc_en, ifid_en, idexe_en, exemem_en, memwb_en, ifid_flush, idexe_flush}),
          16'(e.ctrl));
    check("state", 16'(state), 16'(e.st));
    check("stall_cycles", stall_cycles, e.sc);
    check("mem_timeout", 16'(mem_timeout), 16'(e.to));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = 4'd1; id_rs2 = 4'd2; exe_rd = 4'd7;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    exe_rd_mem_en = 1'b0; exe_wb_en = 1'b1;
    exe_jump_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    exe_rd = 4'd3; exe_rd_mem_en = 1'b1; exe_wb_en = 1'b1;
    id_rs2 = 4'd3; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    step(C_FRZ, S_RUN, 16'd0, 1'b0);            // outputs gated while in reset
    rst = 1'b0;

    step(C_DEF, S_RUN, 16'd0, 1'b0);            // idle
    id_rs1 = 4'd9; id_rs2 = 4'd4;
    step(C_DEF, S_RUN, 16'd0, 1'b0);

    set_load_use();                             // load-use via rs2
    step(C_LU,  S_RUN, 16'd0, 1'b0);
    idle_inputs();
    step(C_DEF, S_RUN, 16'd1, 1'b0);
    set_load_use(); id_uses_rs2 = 1'b0;         // rs2 not read: no hazard
    step(C_DEF, S_RUN, 16'd1, 1'b0);
    set_load_use(); exe_wb_en = 1'b0;           // load without writeback: no hazard
    step(C_DEF, S_RUN, 16'd1, 1'b0);
    idle_inputs(); exe_rd = 4'd3; exe_rd_mem_en = 1'b1; id_rs1 = 4'd3;   // via rs1
    step(C_LU,  S_RUN, 16'd1, 1'b0);
    idle_inputs();
    step(C_DEF, S_RUN, 16'd2, 1'b0);

    exe_jump_taken = 1'b1;                      // taken jump: two flush cycles
    step(C_JMP, S_RUN, 16'd2, 1'b0);
    exe_jump_taken = 1'b0;
    step(C_FL,  S_FL,  16'd2, 1'b0);
    step(C_DEF, S_RUN, 16'd2, 1'b0);

    mem_req = 1'b1; mem_ready = 1'b0;           // three-cycle memory wait
    step(C_FRZ, S_RUN, 16'd2, 1'b0);
    step(C_FRZ, S_MW,  16'd3, 1'b0);
    step(C_FRZ, S_MW,  16'd4, 1'b0);
    mem_ready = 1'b1;
    step(C_DEF, S_MW,  16'd5, 1'b0);
    step(C_DEF, S_RUN, 16'd5, 1'b0);            // req with ready in RUN: no stall
    mem_req = 1'b0;

    mem_req = 1'b1; mem_ready = 1'b0;           // all three hazards at once
    exe_jump_taken = 1'b1; set_load_use();
    step(C_FRZ, S_RUN, 16'd5, 1'b0);
    step(C_FRZ, S_MW,  16'd6, 1'b0);
    mem_ready = 1'b1;
    step(C_DEF, S_MW,  16'd7, 1'b0);
    mem_req = 1'b0; mem_ready = 1'b0;
    step(C_JMP, S_RUN, 16'd7, 1'b0);            // jump outranks load-use after release
    idle_inputs();
    step(C_FL,  S_FL,  16'd7, 1'b0);
    step(C_DEF, S_RUN, 16'd7, 1'b0);

    exe_jump_taken = 1'b1;                      // memory freeze during FLUSH
    step(C_JMP, S_RUN, 16'd7, 1'b0);
    exe_jump_taken = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    step(C_FRZ, S_FL,  16'd7, 1'b0);
    step(C_FRZ, S_MW,  16'd8, 1'b0);
    mem_ready = 1'b1;
    step(C_DEF, S_MW,  16'd9, 1'b0);
    mem_req = 1'b0; mem_ready = 1'b0;
    step(C_DEF, S_RUN, 16'd9, 1'b0);

    mem_req = 1'b1; mem_ready = 1'b0;           // timeout: 15 frozen, release on 16th
    step(C_FRZ, S_RUN, 16'd9, 1'b0);
    for (int i = 0; i < 14; i++)
      step(C_FRZ, S_MW, 16'(10 + i), 1'b0);
    step(C_DEF, S_MW,  16'd24, 1'b0);
    mem_req = 1'b0;
    step(C_DEF, S_RUN, 16'd24, 1'b1);
    step(C_DEF, S_RUN, 16'd24, 1'b1);           // sticky

    mem_req = 1'b1;                             // reset during MEM_WAIT
    step(C_FRZ, S_RUN, 16'd24, 1'b1);
    step(C_FRZ, S_MW,  16'd25, 1'b1);
    rst = 1'b1;
    step(C_FRZ, S_MW,  16'd26, 1'b1);
    rst = 1'b0; mem_req = 1'b0;
    step(C_DEF, S_RUN, 16'd0, 1'b0);

    exe_jump_taken = 1'b1;                      // reset during FLUSH
    step(C_JMP, S_RUN, 16'd0, 1'b0);
    exe_jump_taken = 1'b0; rst = 1'b1;
    step(C_FRZ, S_FL,  16'd0, 1'b0);
    rst = 1'b0;
    step(C_DEF, S_RUN, 16'd0, 1'b0);

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
